leaky_lif_array: RTL and testbench
==================================

Name: leaky_lif_array

Overview:
- Parametrised multi-channel leaky integrate-and-fire (LIF) neuron array. Next generation of the single leaky neuron.
- Adds N_CH parallel channels and runtime-configurable threshold and leak shift.
- Adds reset-to-zero or reset-by-subtraction, a refractory period and a step strobe.
- Sits between the input-switch/current bus and the 7-seg/bidir outputs of the tiny-tapeout top level.

Parameters:
- N_CH, 4, number of independent neuron channels.
- W, 8, membrane-state and input-current width (unsigned).
- REFRAC, 2, refractory length in steps after a spike; 0 = none.
- SHW, 3, width of the leak_shift port; must satisfy 2^SHW >= W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- step_en  in  1  one neuron time-step per cycle sampled high.
- current  in  N_CH*W  per-channel input current; channel c occupies bits [c*W +: W].
- threshold  in  W  firing threshold, shared by all channels; 0 = firing disabled.
- leak_shift  in  SHW  decay = state >> leak_shift; 0 = no leak.
- reset_mode  in  1  0 = reset to zero on spike; 1 = subtract threshold.
- state  out  N_CH*W  registered membrane state per channel.
- spike  out  N_CH  registered spike flag per channel.
- refrac_busy  out  N_CH  high while the channel's refractory counter is nonzero.

Behaviour:
- Reset: one clock, synchronous, active-low on rst_n.
  - Sampled low: state, spike, refrac_busy and refractory counters all clear to 0.
  - Reset dominates step_en.
  - Reset mid-refractory aborts the refractory period.
- No step (step_en=0): state and counters hold; spike = 0.
- Step (step_en=1), per channel, all channels in the same cycle. Results appear on the outputs on the following edge (1-cycle latency).
  - Refractory branch (cnt > 0): cnt <= cnt-1; state holds (no leak, no integration); spike <= 0.
  - Otherwise:
    - leaked = (leak_shift==0) ? state : state - (state >> leak_shift).
    - sum = leaked + current, computed in W+1 bits, saturated to 2^W-1.
    - fire = (threshold != 0) && (sum >= threshold).
    - fire=1:
      - spike <= 1.
      - state <= 0 (reset_mode=0) or sum - threshold (reset_mode=1; never negative).
      - cnt <= REFRAC.
    - fire=0: spike <= 0; state <= sum.
- refrac_busy is the registered (cnt != 0). It rises with the spike and drops on the edge at which cnt reaches 0.
- Back-to-back steps may produce spike high on consecutive cycles only when REFRAC=0.
- threshold, leak_shift and reset_mode are sampled on step cycles only. A change takes effect at the next step.
- Shift amounts >= W yield decay 0 from the shift, so leaked = state.

Optional Feature:
- Macro: LEAKY_SPIKE_CNT_EN.
- Defined:
  - Adds output spike_cnt (N_CH*8): per-channel saturating 8-bit spike counters, incremented on every fire.
  - Adds input cnt_clr (1): clears all counters synchronously.
  - If cnt_clr and fire occur in the same cycle, the clear wins.
  - Counters are cleared by rst_n.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package leaky_pkg holds:
  - localparam RESET_ZERO=1'b0, RESET_SUB=1'b1.
  - The saturating-add helper function.
- Sub-module leaky_lif_cell holds one channel: state register, refractory counter, fire logic and optional counter.
- leaky_lif_array instantiates N_CH leaky_lif_cell in a generate loop and shares the config inputs.

Test Plan (W=8, N_CH=4, REFRAC=2):
- Reset: rst_n=0 with step_en=1 and current=0xFF for 3 cycles -> state=0, spike=0, refrac_busy=0 every cycle.
- Leak convergence, ch0: current=40, leak_shift=1, threshold=200, step every cycle -> state 40,60,70,75,78,79,80,80; spike never asserts.
- Fire + refractory + zero-reset, ch1: current=60, leak_shift=0, threshold=100, reset_mode=0, continuous steps:
  - State 60, then 0 with spike=1 and refrac_busy=1.
  - Held at 0 for 2 steps; refrac_busy drops after the 2nd of them.
  - Next step state=60.
- Subtract-reset, ch2: same stimulus, reset_mode=1 -> after the fire step state=20 and spike=1.
- Saturation / disabled threshold, ch3: current=255, threshold=0 -> state=255 and holds, spike=0.
- Gaps and mid-reset:
  - step_en toggling 1,0,1 -> state changes only on step cycles.
  - rst_n low during refractory -> refrac_busy=0 next cycle; the next step integrates normally.
  - With LEAKY_SPIKE_CNT_EN: spike_cnt increments per fire and saturates at 255; cnt_clr wins a same-cycle fire.

Source files
------------

// File: rtl/leaky_pkg.sv
// Shared constants and helpers for the leaky LIF neuron array.
// Optional spike counters are enabled by defining LEAKY_SPIKE_CNT_EN.
package leaky_pkg;

   localparam logic RESET_ZERO = 1'b0;
   localparam logic RESET_SUB  = 1'b1;

   // Unsigned add clamped to 2^w-1; valid for w in 1..32.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      logic [32:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/leaky_lif_cell.sv
// One leaky integrate-and-fire channel: membrane state, refractory counter and fire logic.
// LEAKY_SPIKE_CNT_EN adds a saturating 8-bit spike counter with synchronous clear.
module leaky_lif_cell
   import leaky_pkg::*;
#(
   parameter int W      = 8,
   parameter int REFRAC = 2,
   parameter int SHW    = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           step_en,
   input  logic [W-1:0]   current,
   input  logic [W-1:0]   threshold,
   input  logic [SHW-1:0] leak_shift,
   input  logic           reset_mode,
`ifdef LEAKY_SPIKE_CNT_EN
   input  logic           cnt_clr,
   output logic [7:0]     spike_cnt,
`endif
   output logic [W-1:0]   state,
   output logic           spike,
   output logic           refrac_busy
);

   localparam int CW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(REFRAC);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [W-1:0]  decay;
   logic [W-1:0]  leaked;
   logic [W-1:0]  sum;
   logic [W-1:0]  state_nxt;
   logic          fire;
   logic          in_refrac;
   logic          spike_nxt;

   always_comb begin
      decay     = '0;
      leaked    = state;
      sum       = '0;
      fire      = 1'b0;
      in_refrac = (cnt != '0);
      state_nxt = state;
      cnt_nxt   = cnt;
      spike_nxt = 1'b0;

      // Shift amounts >= W naturally produce zero decay.
      if (leak_shift != '0)
         decay = state >> leak_shift;
      leaked = state - decay;
      sum    = W'(sat_add(32'(leaked), 32'(current), W));
      fire   = (threshold != '0) && (sum >= threshold);

      if (step_en) begin
         if (in_refrac) begin
            cnt_nxt = cnt - CNT_ONE;
         end else if (fire) begin
            spike_nxt = 1'b1;
            state_nxt = (reset_mode == RESET_SUB) ? (sum - threshold) : '0;
            cnt_nxt   = CNT_LOAD;
         end else begin
            state_nxt = sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= '0;
         spike       <= 1'b0;
         cnt         <= '0;
         refrac_busy <= 1'b0;
      end else begin
         state       <= state_nxt;
         spike       <= spike_nxt;
         cnt         <= cnt_nxt;
         refrac_busy <= (cnt_nxt != '0);
      end
   end

`ifdef LEAKY_SPIKE_CNT_EN
   // Clear beats a same-cycle fire.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr)
         spike_cnt <= '0;
      else if (spike_nxt && (spike_cnt != 8'hFF))
         spike_cnt <= spike_cnt + 8'd1;
   end
`endif

endmodule

// File: rtl/leaky_lif_array.sv
// N_CH parallel leaky LIF channels sharing threshold, leak shift and reset mode.
// Define LEAKY_SPIKE_CNT_EN to add per-channel spike counters (spike_cnt, cnt_clr).
module leaky_lif_array
   import leaky_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int W      = 8,
   parameter int REFRAC = 2,
   parameter int SHW    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step_en,
   input  logic [N_CH*W-1:0] current,
   input  logic [W-1:0]      threshold,
   input  logic [SHW-1:0]    leak_shift,
   input  logic              reset_mode,
`ifdef LEAKY_SPIKE_CNT_EN
   input  logic              cnt_clr,
   output logic [N_CH*8-1:0] spike_cnt,
`endif
   output logic [N_CH*W-1:0] state,
   output logic [N_CH-1:0]   spike,
   output logic [N_CH-1:0]   refrac_busy
);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      leaky_lif_cell #(
         .W      (W),
         .REFRAC (REFRAC),
         .SHW    (SHW)
      ) u_cell (
         .clk         (clk),
         .rst_n       (rst_n),
         .step_en     (step_en),
         .current     (current[c*W +: W]),
         .threshold   (threshold),
         .leak_shift  (leak_shift),
         .reset_mode  (reset_mode),
`ifdef LEAKY_SPIKE_CNT_EN
         .cnt_clr     (cnt_clr),
         .spike_cnt   (spike_cnt[c*8 +: 8]),
`endif
         .state       (state[c*W +: W]),
         .spike       (spike[c]),
         .refrac_busy (refrac_busy[c])
      );
   end

endmodule

// File: tb/tb_leaky_lif_array.sv
// Directed bench for leaky_lif_array (N_CH=4, W=8, REFRAC=2) with an expected-value queue.
// Spike counter checks are compiled in when LEAKY_SPIKE_CNT_EN is defined.
module tb_leaky_lif_array;

   localparam int N_CH = 4;
   localparam int W    = 8;
   localparam int SHW  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              step_en;
   logic [N_CH*W-1:0] current;
   logic [W-1:0]      threshold;
   logic [SHW-1:0]    leak_shift;
   logic              reset_mode;
   logic [N_CH*W-1:0] state;
   logic [N_CH-1:0]   spike;
   logic [N_CH-1:0]   refrac_busy;
`ifdef LEAKY_SPIKE_CNT_EN
   logic              cnt_clr;
   logic [N_CH*8-1:0] spike_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Each entry: {state, spike, refrac_busy} for one channel.
   logic [W+1:0] exp_q[$];
   int           ch_q[$];
   string        tag_q[$];

   leaky_lif_array #(.N_CH(N_CH), .W(W), .REFRAC(2), .SHW(SHW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_en     (step_en),
      .current     (current),
      .threshold   (threshold),
      .leak_shift  (leak_shift),
      .reset_mode  (reset_mode),
`ifdef LEAKY_SPIKE_CNT_EN
      .cnt_clr     (cnt_clr),
      .spike_cnt   (spike_cnt),
`endif
      .state       (state),
      .spike       (spike),
      .refrac_busy (refrac_busy)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // driver / scoreboard tasks
   task automatic set_cur(input int ch, input logic [W-1:0] v);
      current[ch*W +: W] = v;
   endtask

   task automatic expect_ch(input string tag, input int ch, input logic [W-1:0] st,
                            input logic sp, input logic bz);
      exp_q.push_back({st, sp, bz});
      ch_q.push_back(ch);
      tag_q.push_back(tag);
   endtask

   task automatic tick();
      logic [W+1:0] exp_v;
      logic [W+1:0] obs_v;
      int           ch;
      string        tag;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         ch    = ch_q.pop_front();
         tag   = tag_q.pop_front();
         obs_v = {state[ch*W +: W], spike[ch], refrac_busy[ch]};
         n_vec++;
         assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s ch%0d: got state=%0d spike=%0b busy=%0b, want state=%0d spike=%0b busy=%0b",
                   tag, ch, obs_v[W+1:2], obs_v[1], obs_v[0], exp_v[W+1:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic reset_cycle();
      rst_n = 1'b0;
      for (int c = 0; c < N_CH; c++) expect_ch("reset", c, 8'd0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
   endtask

`ifdef LEAKY_SPIKE_CNT_EN
   task automatic chk_cnt(input string tag, input int ch, input logic [7:0] want);
      n_vec++;
      assert (spike_cnt[ch*8 +: 8] === want) else begin
         n_err++;
         $error("FAIL %s ch%0d: got spike_cnt=%0d, want %0d", tag, ch, spike_cnt[ch*8 +: 8], want);
      end
   endtask
`endif

   // directed stimulus
   initial begin
      logic [W-1:0] leak_seq [8];
      leak_seq = '{8'd40, 8'd60, 8'd70, 8'd75, 8'd78, 8'd79, 8'd80, 8'd80};

      rst_n      = 1'b0;
      step_en    = 1'b1;
      current    = '1;
      threshold  = 8'd100;
      leak_shift = '0;
      reset_mode = 1'b0;
`ifdef LEAKY_SPIKE_CNT_EN
      cnt_clr    = 1'b0;
`endif
      #1;

      // Reset dominates step_en with full-scale current.
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < N_CH; c++) expect_ch("rst_hold", c, 8'd0, 1'b0, 1'b0);
         tick();
      end

      // Leak convergence on ch0.
      rst_n      = 1'b1;
      current    = '0;
      set_cur(0, 8'd40);
      leak_shift = 3'd1;
      threshold  = 8'd200;
      for (int i = 0; i < 8; i++) begin
         expect_ch("leak", 0, leak_seq[i], 1'b0, 1'b0);
         expect_ch("leak_idle", 1, 8'd0, 1'b0, 1'b0);
         tick();
      end

      // Fire, refractory, zero-reset on ch1.
      reset_cycle();
      current    = '0;
      set_cur(1, 8'd60);
      leak_shift = '0;
      threshold  = 8'd100;
      reset_mode = 1'b0;
      expect_ch("zr_int", 1, 8'd60, 1'b0, 1'b0); tick();
      expect_ch("zr_fire", 1, 8'd0, 1'b1, 1'b1); tick();
      expect_ch("zr_ref1", 1, 8'd0, 1'b0, 1'b1); tick();
      expect_ch("zr_ref2", 1, 8'd0, 1'b0, 1'b0); tick();
      expect_ch("zr_resume", 1, 8'd60, 1'b0, 1'b0); tick();

      // Subtract-reset on ch2.
      reset_cycle();
      current    = '0;
      set_cur(2, 8'd60);
      reset_mode = 1'b1;
      expect_ch("sub_int", 2, 8'd60, 1'b0, 1'b0); tick();
      expect_ch("sub_fire", 2, 8'd20, 1'b1, 1'b1); tick();
      expect_ch("sub_ref1", 2, 8'd20, 1'b0, 1'b1); tick();
      expect_ch("sub_ref2", 2, 8'd20, 1'b0, 1'b0); tick();
      expect_ch("sub_int2", 2, 8'd80, 1'b0, 1'b0); tick();
      expect_ch("sub_fire2", 2, 8'd40, 1'b1, 1'b1); tick();

      // Saturation with firing disabled on ch3.
      reset_cycle();
      current    = '0;
      set_cur(3, 8'd255);
      threshold  = 8'd0;
      reset_mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_ch("sat", 3, 8'd255, 1'b0, 1'b0);
         tick();
      end

      // Step gaps on ch1: state and counter hold, spike only on the step.
      reset_cycle();
      current   = '0;
      set_cur(1, 8'd60);
      threshold = 8'd100;
      step_en = 1'b1; expect_ch("gap_s1", 1, 8'd60, 1'b0, 1'b0); tick();
      step_en = 1'b0; expect_ch("gap_n1", 1, 8'd60, 1'b0, 1'b0); tick();
      step_en = 1'b1; expect_ch("gap_fire", 1, 8'd0, 1'b1, 1'b1); tick();
      step_en = 1'b0; expect_ch("gap_n2", 1, 8'd0, 1'b0, 1'b1); tick();
      step_en = 1'b1; expect_ch("gap_ref1", 1, 8'd0, 1'b0, 1'b1); tick();
      expect_ch("gap_ref2", 1, 8'd0, 1'b0, 1'b0); tick();

      // Reset in the middle of refractory.
      expect_ch("mid_int", 1, 8'd60, 1'b0, 1'b0); tick();
      expect_ch("mid_fire", 1, 8'd0, 1'b1, 1'b1); tick();
      rst_n = 1'b0; expect_ch("mid_rst", 1, 8'd0, 1'b0, 1'b0); tick();
      rst_n = 1'b1; expect_ch("mid_after", 1, 8'd60, 1'b0, 1'b0); tick();

`ifdef LEAKY_SPIKE_CNT_EN
      // Spike counter on ch3: fires every third step at threshold 1.
      current   = '0;
      set_cur(3, 8'd255);
      threshold = 8'd1;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk_cnt("cnt_rst", 3, 8'd0);
      tick(); chk_cnt("cnt_first", 3, 8'd1);
      tick(); tick(); chk_cnt("cnt_ref", 3, 8'd1);
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk_cnt("cnt_clr_win", 3, 8'd0);
      chk_cnt("cnt_idle", 0, 8'd0);
      for (int i = 0; i < 800; i++) tick();
      chk_cnt("cnt_sat", 3, 8'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
